// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer in front of the byte-addressed data memory.
// Optional feature: define DMEM_ARB_RR_EN for round-robin arbitration (default: port 0 fixed priority).
module dmem_arbiter #(
    parameter int unsigned DEPTH = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic [31:0] m0_req_addr,
    input  logic [31:0] m0_req_wdata,
    input  logic        m0_req_we,
    input  logic [2:0]  m0_req_funct3,
    output logic        m0_rsp_valid,
    output logic [31:0] m0_rsp_rdata,
    output logic        m0_rsp_err,
    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic [31:0] m1_req_addr,
    input  logic [31:0] m1_req_wdata,
    input  logic        m1_req_we,
    input  logic [2:0]  m1_req_funct3,
    output logic        m1_rsp_valid,
    output logic [31:0] m1_rsp_rdata,
    output logic        m1_rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_funct3,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_r, state_next_s;
    logic        any_valid_s, grant_s, handshake_s;
    logic [31:0] sel_addr_s, sel_wdata_s;
    logic        sel_we_s, sel_err_s;
    logic [2:0]  sel_funct3_s;
    logic [31:0] addr_r, wdata_r;
    logic [2:0]  funct3_r;
    logic        we_r, err_r, port_r, mem_write_r, mem_read_r;
    logic        m0_rsp_valid_r, m1_rsp_valid_r, m0_rsp_err_r, m1_rsp_err_r;
    logic [31:0] m0_rsp_rdata_r, m1_rsp_rdata_r;
`ifdef DMEM_ARB_RR_EN
    logic        ptr_r;
`endif

    // Range check uses 33 bits so an access near 0xFFFFFFFF cannot wrap back into range.
    function automatic logic access_error(input logic [31:0] addr, input logic we,
                                          input logic [2:0] funct3);
        logic        bad_code;
        logic        misaligned;
        logic [32:0] size_m1;
        logic [32:0] last_byte;
        case (funct3[1:0])
            2'b00:   size_m1 = 33'd0;
            2'b01:   size_m1 = 33'd1;
            default: size_m1 = 33'd3;
        endcase
        if (we) begin
            bad_code = (funct3 != 3'b000) && (funct3 != 3'b001) && (funct3 != 3'b010);
        end else begin
            bad_code = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        case (funct3)
            3'b001, 3'b101: misaligned = addr[0];
            3'b010:         misaligned = (addr[1:0] != 2'b00);
            default:        misaligned = 1'b0;
        endcase
        last_byte = {1'b0, addr} + size_m1;
        return bad_code || misaligned || (last_byte >= 33'(DEPTH));
    endfunction

    // Grant selection: a lone requester always wins; ties go to the preferred port.
    always_comb begin
        any_valid_s = m0_req_valid || m1_req_valid;
`ifdef DMEM_ARB_RR_EN
        if (m0_req_valid && m1_req_valid) begin
            grant_s = ptr_r;
        end else begin
            grant_s = !m0_req_valid;
        end
`else
        grant_s = !m0_req_valid;
`endif
    end

    // Request field mux and validation for the granted port.
    always_comb begin
        if (grant_s) begin
            sel_addr_s   = m1_req_addr;
            sel_wdata_s  = m1_req_wdata;
            sel_we_s     = m1_req_we;
            sel_funct3_s = m1_req_funct3;
        end else begin
            sel_addr_s   = m0_req_addr;
            sel_wdata_s  = m0_req_wdata;
            sel_we_s     = m0_req_we;
            sel_funct3_s = m0_req_funct3;
        end
        sel_err_s = access_error(sel_addr_s, sel_we_s, sel_funct3_s);
    end

    // Next-state logic and request handshake.
    always_comb begin
        state_next_s = state_r;
        handshake_s  = 1'b0;
        case (state_r)
            IDLE: begin
                handshake_s = any_valid_s && !rst;
                if (any_valid_s) begin
                    state_next_s = ACCESS;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCESS:  state_next_s = RESP;
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
        m0_req_ready = handshake_s && !grant_s;
        m1_req_ready = handshake_s && grant_s;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Request capture, memory enables and per-port response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r         <= 32'd0;
            wdata_r        <= 32'd0;
            funct3_r       <= 3'd0;
            we_r           <= 1'b0;
            err_r          <= 1'b0;
            port_r         <= 1'b0;
            mem_write_r    <= 1'b0;
            mem_read_r     <= 1'b0;
            m0_rsp_valid_r <= 1'b0;
            m1_rsp_valid_r <= 1'b0;
            m0_rsp_err_r   <= 1'b0;
            m1_rsp_err_r   <= 1'b0;
            m0_rsp_rdata_r <= 32'd0;
            m1_rsp_rdata_r <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (handshake_s) begin
                        addr_r      <= sel_addr_s;
                        wdata_r     <= sel_wdata_s;
                        funct3_r    <= sel_funct3_s;
                        we_r        <= sel_we_s;
                        err_r       <= sel_err_s;
                        port_r      <= grant_s;
                        mem_write_r <= sel_we_s && !sel_err_s;
                        mem_read_r  <= !sel_we_s && !sel_err_s;
                    end
                end
                ACCESS: begin
                    mem_write_r <= 1'b0;
                    mem_read_r  <= 1'b0;
                    if (port_r) begin
                        m1_rsp_valid_r <= 1'b1;
                        m1_rsp_err_r   <= err_r;
                        m1_rsp_rdata_r <= (we_r || err_r) ? 32'd0 : mem_rdata;
                    end else begin
                        m0_rsp_valid_r <= 1'b1;
                        m0_rsp_err_r   <= err_r;
                        m0_rsp_rdata_r <= (we_r || err_r) ? 32'd0 : mem_rdata;
                    end
                end
                RESP: begin
                    m0_rsp_valid_r <= 1'b0;
                    m1_rsp_valid_r <= 1'b0;
                    m0_rsp_err_r   <= 1'b0;
                    m1_rsp_err_r   <= 1'b0;
                    m0_rsp_rdata_r <= 32'd0;
                    m1_rsp_rdata_r <= 32'd0;
                end
                default: begin
                    mem_write_r <= 1'b0;
                    mem_read_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Preference flips to the other port after every grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= 1'b0;
        end else if (handshake_s) begin
            ptr_r <= !grant_s;
        end
    end
`endif

    assign mem_addr     = addr_r;
    assign mem_wdata    = wdata_r;
    assign mem_funct3   = funct3_r;
    assign mem_write    = mem_write_r && !rst;
    assign mem_read     = mem_read_r && !rst;
    assign m0_rsp_valid = m0_rsp_valid_r;
    assign m1_rsp_valid = m1_rsp_valid_r;
    assign m0_rsp_err   = m0_rsp_err_r;
    assign m1_rsp_err   = m1_rsp_err_r;
    assign m0_rsp_rdata = m0_rsp_rdata_r;
    assign m1_rsp_rdata = m1_rsp_rdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed test-plan steps plus random requests
// checked against a byte-array reference model of the memory access rules.
module tb_dmem_arbiter;
    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_valid, m0_req_ready, m0_req_we, m0_rsp_valid, m0_rsp_err;
    logic        m1_req_valid, m1_req_ready, m1_req_we, m1_rsp_valid, m1_rsp_err;
    logic [31:0] m0_req_addr, m0_req_wdata, m0_rsp_rdata;
    logic [31:0] m1_req_addr, m1_req_wdata, m1_rsp_rdata;
    logic [2:0]  m0_req_funct3, m1_req_funct3;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_funct3;
    logic        mem_write, mem_read;

    int checks = 0;
    int failures = 0;
    logic [7:0]  dev_mem [DEPTH] = '{default: 8'h00};
    logic [7:0]  ref_mem [DEPTH] = '{default: 8'h00};
    logic [31:0] rd_word;
    logic [32:0] rd_ea;

    dmem_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
        .m0_req_wdata(m0_req_wdata), .m0_req_we(m0_req_we), .m0_req_funct3(m0_req_funct3),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_err(m0_rsp_err),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
        .m1_req_wdata(m1_req_wdata), .m1_req_we(m1_req_we), .m1_req_funct3(m1_req_funct3),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_err(m1_rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
        .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory device: combinational, size-formatted read data.
    always_comb begin
        rd_word = 32'd0;
        rd_ea   = 33'd0;
        for (int i = 0; i < 4; i++) begin
            rd_ea = {1'b0, mem_addr} + 33'(i);
            rd_word[8*i +: 8] = (rd_ea < 33'(DEPTH)) ? dev_mem[rd_ea[11:0]] : 8'h00;
        end
        case (mem_funct3)
            3'b000:  mem_rdata = {{24{rd_word[7]}}, rd_word[7:0]};
            3'b001:  mem_rdata = {{16{rd_word[15]}}, rd_word[15:0]};
            3'b100:  mem_rdata = {24'd0, rd_word[7:0]};
            3'b101:  mem_rdata = {16'd0, rd_word[15:0]};
            default: mem_rdata = rd_word;
        endcase
    end

    // Memory device: byte-lane store commit.
    always @(posedge clk) begin
        if (mem_write) begin
            for (int i = 0; i < 4; i++) begin
                if ((i < ((mem_funct3[1:0] == 2'b00) ? 1 : (mem_funct3[1:0] == 2'b01) ? 2 : 4)) &&
                    (({1'b0, mem_addr} + 33'(i)) < 33'(DEPTH))) begin
                    dev_mem[mem_addr[11:0] + 12'(i)] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: apply the access rules to a byte array.
    task automatic ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic err, output logic [31:0] rd);
        int sz;
        longint unsigned last;
        logic [31:0] w;
        sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        last = {32'd0, addr} + 64'(sz) - 64'd1;
        if (we) err = !(f3 inside {3'b000, 3'b001, 3'b010});
        else    err = f3 inside {3'b011, 3'b110, 3'b111};
        if ((addr % sz) != 0) err = 1'b1;
        if (last >= 64'(DEPTH)) err = 1'b1;
        rd = 32'd0;
        w = 32'd0;
        if (!err) begin
            for (int i = 0; i < sz; i++) begin
                if (we) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
                else    w[8*i +: 8] = ref_mem[addr + 32'(i)];
            end
            if (!we) begin
                case (f3)
                    3'b000:  rd = {{24{w[7]}}, w[7:0]};
                    3'b001:  rd = {{16{w[15]}}, w[15:0]};
                    default: rd = w;
                endcase
            end
        end
    endtask

    task automatic drive(input int p, input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 0) begin
            m0_req_valid = v; m0_req_we = we; m0_req_funct3 = f3;
            m0_req_addr = addr; m0_req_wdata = wdata;
        end else begin
            m1_req_valid = v; m1_req_we = we; m1_req_funct3 = f3;
            m1_req_addr = addr; m1_req_wdata = wdata;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ":flags"}, {26'd0, m0_rsp_valid, m1_rsp_valid, m0_rsp_err, m1_rsp_err,
                              mem_write, mem_read}, 32'd0);
        chk({tag, ":rdata0"}, m0_rsp_rdata, 32'd0);
        chk({tag, ":rdata1"}, m1_rsp_rdata, 32'd0);
        chk({tag, ":mem_addr"}, mem_addr, 32'd0);
        chk({tag, ":mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, ":mem_funct3"}, {29'd0, mem_funct3}, 32'd0);
    endtask

    // One complete transaction on port p with timing, memory-side and response checks.
    task automatic issue(input int p, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input string tag);
        logic exp_err;
        logic [31:0] exp_rd;
        int lat;
        ref_access(we, f3, addr, wdata, exp_err, exp_rd);
        @(negedge clk);
        drive(p, 1'b1, we, f3, addr, wdata);
        #1;
        chk({tag, ":ready"}, {31'd0, (p == 0) ? m0_req_ready : m1_req_ready}, 32'd1);
        chk({tag, ":other_ready"}, {31'd0, (p == 0) ? m1_req_ready : m0_req_ready}, 32'd0);
        @(posedge clk);
        #1;
        drive(p, 1'b0, ~we, ~f3, $urandom(), $urandom());
        @(negedge clk);
        chk({tag, ":mem_read"}, {31'd0, mem_read}, {31'd0, !we && !exp_err});
        chk({tag, ":mem_write"}, {31'd0, mem_write}, {31'd0, we && !exp_err});
        chk({tag, ":mem_addr"}, mem_addr, addr);
        chk({tag, ":mem_funct3"}, {29'd0, mem_funct3}, {29'd0, f3});
        if (we) chk({tag, ":mem_wdata"}, mem_wdata, wdata);
        chk({tag, ":early_rsp"}, {30'd0, m0_rsp_valid, m1_rsp_valid}, 32'd0);
        lat = 0;
        for (int n = 2; n <= 6; n++) begin
            @(negedge clk);
            if (((p == 0) ? m0_rsp_valid : m1_rsp_valid) === 1'b1) begin
                lat = n;
                break;
            end
        end
        chk({tag, ":latency"}, 32'(lat), 32'd2);
        chk({tag, ":rdata"}, (p == 0) ? m0_rsp_rdata : m1_rsp_rdata, exp_rd);
        chk({tag, ":err"}, {31'd0, (p == 0) ? m0_rsp_err : m1_rsp_err}, {31'd0, exp_err});
        chk({tag, ":other_rsp"}, {31'd0, (p == 0) ? m1_rsp_valid : m0_rsp_valid}, 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned sel;
        sel = $urandom_range(0, 9);
        if (sel <= 6)      return 32'($urandom_range(0, 63));
        else if (sel == 7) return 32'(DEPTH - 4 + int'($urandom_range(0, 7)));
        else if (sel == 8) return 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
        else               return 32'($urandom_range(0, DEPTH - 1));
    endfunction

    initial begin
        int grant;
        int pulses;
        int exp_grant;
        rst = 1'b1;
        drive(0, 1'b1, 1'b0, 3'b010, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 3'b010, 32'd0, 32'd0);
        @(negedge clk);
        chk("rst_ready_gated", {30'd0, m0_req_ready, m1_req_ready}, 32'd0);
        chk("rst_enables_gated", {30'd0, mem_write, mem_read}, 32'd0);
        drive(0, 1'b0, 1'b0, 3'b010, 32'd0, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");

        issue(0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, "sw_10");
        issue(0, 1'b0, 3'b010, 32'h10, 32'd0, "lw_10");
        chk("lw_10_value", m0_rsp_rdata, 32'hDEAD_BEEF);
        issue(1, 1'b1, 3'b000, 32'h20, 32'h0000_0080, "sb_20");
        issue(1, 1'b0, 3'b000, 32'h20, 32'd0, "lb_20");
        chk("lb_20_value", m1_rsp_rdata, 32'hFFFF_FF80);
        issue(1, 1'b0, 3'b100, 32'h20, 32'd0, "lbu_20");
        chk("lbu_20_value", m1_rsp_rdata, 32'h0000_0080);

        issue(0, 1'b0, 3'b010, 32'h12, 32'd0, "lw_misaligned");
        issue(0, 1'b0, 3'b001, 32'h13, 32'd0, "lh_misaligned");
        issue(1, 1'b1, 3'b100, 32'h30, 32'hAA, "store_bad_f3");
        issue(0, 1'b0, 3'b010, 32'hFFC, 32'd0, "lw_last_word");
        issue(0, 1'b0, 3'b010, 32'hFFE, 32'd0, "lw_past_end");
        chk("lw_past_end_err", {31'd0, m0_rsp_err}, 32'd1);
        issue(1, 1'b0, 3'b010, 32'hFFFF_FFFC, 32'd0, "lw_wrap");

        // Store aborted by reset while in ACCESS.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 3'b010, 32'h40, 32'h1234_5678);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_mem_write", {31'd0, mem_write}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals("post_abort");
        pulses = 0;
        for (int n = 0; n < 4; n++) begin
            if (m0_rsp_valid || m1_rsp_valid) pulses++;
            @(negedge clk);
        end
        chk("abort_no_rsp", 32'(pulses), 32'd0);
        issue(0, 1'b0, 3'b010, 32'h40, 32'd0, "lw_40_after_abort");
        chk("lw_40_value", m0_rsp_rdata, 32'd0);

        // Arbitration with both ports continuously requesting.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 3'b010, 32'h0, 32'd0);
        drive(1, 1'b1, 1'b0, 3'b010, 32'h4, 32'd0);
        for (int g = 0; g < 4; g++) begin
            for (int n = 0; n < 8; n++) begin
                #1;
                if (m0_req_ready || m1_req_ready) break;
                @(negedge clk);
            end
            chk("arb_onehot", {31'd0, m0_req_ready && m1_req_ready}, 32'd0);
            grant = m1_req_ready ? 1 : (m0_req_ready ? 0 : -1);
`ifdef DMEM_ARB_RR_EN
            exp_grant = g % 2;
`else
            exp_grant = 0;
`endif
            chk($sformatf("arb_grant%0d", g), 32'(grant), 32'(exp_grant));
            @(posedge clk);
            @(negedge clk);
        end
        drive(0, 1'b0, 1'b0, 3'b010, 32'h0, 32'd0);
        drive(1, 1'b0, 1'b0, 3'b010, 32'h4, 32'd0);
        repeat (4) @(negedge clk);

        // Random traffic against the reference model.
        for (int k = 0; k < 60; k++) begin
            issue(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), rand_addr(), $urandom(), $sformatf("rand%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the byte-addressed data memory. Shares the single memory port between the load/store unit (port 0) and the debug/DMA requester (port 1). Validates each request for size, alignment and range before it reaches memory, then returns read data or an error with fixed latency. Sits between the execute stage / debug module and the data memory.

## Interface
- `DEPTH`, 4096: memory size in bytes; addresses `>= DEPTH` are out of range.
- `clk` input 1: clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `m0_req_valid`, `m1_req_valid` input 1: request valid.
- `m0_req_ready`, `m1_req_ready` output 1: request accepted this cycle when valid && ready.
- `m0_req_addr`, `m1_req_addr` input 32: byte address.
- `m0_req_wdata`, `m1_req_wdata` input 32: store data, low bytes used.
- `m0_req_we`, `m1_req_we` input 1: 1 = store, 0 = load.
- `m0_req_funct3`, `m1_req_funct3` input 3: RISC-V load/store size code.
- `m0_rsp_valid`, `m1_rsp_valid` output 1: one-cycle response pulse; no backpressure.
- `m0_rsp_rdata`, `m1_rsp_rdata` output 32: load result; 0 for stores and errors.
- `m0_rsp_err`, `m1_rsp_err` output 1: request rejected, no memory effect.
- `mem_addr` output 32, `mem_wdata` output 32, `mem_funct3` output 3: memory request fields.
- `mem_write` output 1, `mem_read` output 1: memory enables.
- `mem_rdata` input 32: combinational read data from memory.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: grant one valid port. Assert only that port's `req_ready`. On handshake, register addr/wdata/we/funct3/port id, compute error flag, go to ACCESS. No valid request: stay in IDLE.
- ACCESS: drive `mem_*` from registers. Assert `mem_write` = we && !err or `mem_read` = !we && !err. Capture `mem_rdata` into response data (0 if store or err). Go to RESP.
- RESP: pulse granted port's `rsp_valid` with registered rdata/err. Go to IDLE.
- Error conditions, OR'd:
  - load funct3 in {011, 110, 111};
  - store funct3 not in {000, 001, 010};
  - halfword (001/101) with addr[0] = 1;
  - word (010) with addr[1:0] != 0;
  - addr + size − 1 >= DEPTH, computed in 33 bits so no wrap at 0xFFFFFFFF.
- Non-granted port: `req_ready` = 0, `rsp_valid` = 0.
- `req_ready` is 0 in ACCESS and RESP.

## Timing
- Handshake at edge T; ACCESS during cycle T+1 (store commits at end of T+1); `rsp_valid` high during T+2; next acceptance possible at edge T+3. Throughput: one request per 3 cycles.
- Reset values: state IDLE, all `rsp_valid`/`rsp_err` 0, `rsp_rdata` 0, `mem_write`/`mem_read` 0, `mem_addr`/`mem_wdata`/`mem_funct3` 0, arbitration pointer to port 0.
- `mem_write`, `mem_read` and both `req_ready` are gated by `!rst`. A reset asserted during ACCESS commits no store and drops the pending response.
- `req_*` inputs are sampled only at the handshake edge; later changes have no effect on the in-flight access.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin arbitration.
  - 1-bit pointer names the preferred port, initially port 0.
  - After each grant, the pointer moves to the other port.
  - When both ports are valid, the preferred port wins.
- Undefined: fixed priority; port 0 always wins when both are valid.
- A lone valid port is granted immediately in both modes.

## Test plan
- Port 0 SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 -> second response rdata 0xDEADBEEF, err 0; each response exactly 2 cycles after its handshake.
- Port 1 SB 0x20 wdata 0x80, then LB 0x20 and LBU 0x20 -> rdata 0xFFFFFF80 and 0x00000080.
- LW 0x12, LH 0x13, store funct3 100, LW 0xFFC with DEPTH = 4096 -> first three: err 1, rdata 0, `mem_read`/`mem_write` never asserted. LW 0xFFC: err 0. LW 0xFFE: err 1.
- Both ports continuously valid for 4 grants:
  - with `DMEM_ARB_RR_EN`: grant order 0, 1, 0, 1;
  - without it: grant order 0, 0, 0, 0 and port 1 starved.
- Port 0 SW 0x40 wdata 0x12345678; assert `rst` during ACCESS -> no `rsp_valid`. LW 0x40 after reset returns the prior value 0; all outputs at reset values in the cycle after reset.
